apb_slave_regfile: RTL and testbench

//  APB responder (completer) terminating one s_apb_* slave port of the APB crossbar.

---
 rtl/apb_slave_regfile_if.sv | 36 +++
 rtl/apb_slave_regfile.sv | 189 ++++++++++++++++++
 tb/tb_apb_slave_regfile.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_regfile_if
//  Purpose  : APB bus bundle between a requester (master) and the register
//             file responder (slave).
//  Signals  : psel, penable, pwrite, pprot, paddr, pwdata, pstrb  (req -> rsp)
//             pready, prdata, pslverr                           (rsp -> req)
//  Revision : 1.0  initial release
// ============================================================================
interface apb_slave_regfile_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [2:0]            pprot;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [STRB_WIDTH-1:0] pstrb;
   logic                  pready;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_regfile
//  Purpose  : APB completer holding NUM_REGS control/status registers.
//             RW registers live here; RO registers reflect ro_in. A fixed
//             number of wait states is inserted; illegal accesses get pslverr.
//  Ports    : aclk      - clock, all logic on rising edge
//             areset    - synchronous active-high reset
//             s_apb     - APB slave bundle (select/enable/addr/data/strobes in,
//                         registered pready/prdata/pslverr out)
//             reg_q     - flattened register contents (RO slots read as 0)
//             wr_pulse  - one-cycle pulse per register after a legal write
//             ro_in     - flattened hardware values for RO registers
//  Revision : 1.0  initial release
// ============================================================================
module apb_slave_regfile #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int                    NUM_REGS    = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
   input  logic                           aclk,
   input  logic                           areset,
   apb_slave_regfile_if.slave             s_apb,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            wr_pulse,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in
);

   localparam int         OFF_LSB = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
   localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t                r_state;
   logic                  r_pready;
   logic [DATA_WIDTH-1:0] r_prdata;
   logic                  r_pslverr;
   logic [3:0]            r_wait;
   logic                  r_write;
   logic                  r_wr_ok;
   logic [IDX_W-1:0]      r_idx;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_WIDTH-1:0] r_strb;
   logic [NUM_REGS-1:0]   r_wr_pulse;
   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   // ---------------------------------------------------------------------
   // Address decode, evaluated on the live bus during the setup cycle.
   // The range check uses the full-width offset so addresses far above the
   // register window never alias back onto a low index.
   // ---------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] w_off;
   logic [ADDR_WIDTH-1:0] w_idx_full;
   logic                  w_above;
   logic                  w_aligned;
   logic                  w_in_range;
   logic                  w_legal;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_ro;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic [DATA_WIDTH-1:0] w_words [NUM_REGS];
   logic                  w_unused;

   assign w_off      = s_apb.paddr - BASE_ADDR;
   assign w_above    = (s_apb.paddr >= BASE_ADDR);
   assign w_idx_full = w_off >> OFF_LSB;
   assign w_in_range = (w_idx_full < ADDR_WIDTH'(NUM_REGS));
   assign w_idx      = w_idx_full[IDX_W-1:0];

   generate
      if (OFF_LSB == 0) begin : g_align_byte
         assign w_aligned = 1'b1;
      end else begin : g_align_word
         assign w_aligned = (w_off[OFF_LSB-1:0] == '0);
      end
   endgenerate

   assign w_legal = w_above & w_aligned & w_in_range;
   assign w_ro    = w_legal & RO_MASK[w_idx];

   // Per-register read view: RO slots come from hardware, RW from storage.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_words
         assign w_words[gi] = RO_MASK[gi] ? ro_in[gi*DATA_WIDTH +: DATA_WIDTH]
                                          : r_regs[gi];
         assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
      end
   endgenerate

   assign w_rd_data = w_legal ? w_words[w_idx] : '0;

   // Protection bits are accepted but carry no meaning for this block.
   assign w_unused = &{1'b0, s_apb.pprot};

   // ---------------------------------------------------------------------
   // Transfer FSM with all bus responses registered.
   // ---------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state    <= ST_IDLE;
         r_pready   <= 1'b0;
         r_prdata   <= '0;
         r_pslverr  <= 1'b0;
         r_wait     <= '0;
         r_write    <= 1'b0;
         r_wr_ok    <= 1'b0;
         r_idx      <= '0;
         r_wdata    <= '0;
         r_strb     <= '0;
         r_wr_pulse <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         r_wr_pulse <= '0;
         case (r_state)
            ST_IDLE: begin
               // penable without a preceding setup cycle is ignored here.
               if (s_apb.psel && !s_apb.penable) begin
                  r_write <= s_apb.pwrite;
                  r_idx   <= w_idx;
                  r_wdata <= s_apb.pwdata;
                  r_strb  <= s_apb.pstrb;
                  r_wr_ok <= w_legal && !w_ro;
                  r_wait  <= WS_INIT;
                  r_pready <= (WAIT_STATES == 0);
                  if (s_apb.pwrite) begin
                     r_prdata  <= '0;
                     r_pslverr <= !(w_legal && !w_ro);
                  end else begin
                     r_prdata  <= w_rd_data;
                     r_pslverr <= !w_legal;
                  end
                  r_state <= ST_ACCESS;
               end
            end

            ST_ACCESS: begin
               if (!s_apb.psel) begin
                  // Requester abandoned the transfer: drop it without commit.
                  r_state   <= ST_IDLE;
                  r_pready  <= 1'b0;
                  r_prdata  <= '0;
                  r_pslverr <= 1'b0;
                  r_wait    <= '0;
               end else if (r_pready) begin
                  if (s_apb.penable) begin
                     if (r_write && r_wr_ok) begin
                        for (int b = 0; b < STRB_WIDTH; b++) begin
                           if (r_strb[b]) begin
                              r_regs[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                           end
                        end
                        // Pulse even when no strobe is set: the access happened.
                        r_wr_pulse[r_idx] <= 1'b1;
                     end
                     r_state   <= ST_IDLE;
                     r_pready  <= 1'b0;
                     r_prdata  <= '0;
                     r_pslverr <= 1'b0;
                  end
               end else if (r_wait != 4'd0) begin
                  r_wait   <= r_wait - 4'd1;
                  r_pready <= (r_wait == 4'd1);
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_apb.pready  = r_pready;
   assign s_apb.prdata  = r_prdata;
   assign s_apb.pslverr = r_pslverr;
   assign wr_pulse      = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_slave_regfile
//  Purpose  : Directed self-checking bench for apb_slave_regfile. Three
//             instances (0, 3 and 2 wait states) share the bus signals; each
//             has its own psel so only the addressed instance sees a transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_slave_regfile;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [15:0] ROM  = 16'h0008;

   logic        aclk;
   logic        rst;
   logic [2:0]  psel_v;
   logic        penable;
   logic        pwrite;
   logic [2:0]  pprot;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [511:0] ro_in;

   logic [511:0] regq0, regq1, regq2;
   logic [15:0]  wrp0, wrp1, wrp2;
   logic [2:0]   rdy;
   logic [2:0]   err;
   logic [31:0]  rdat [3];

   int n_chk;
   int n_pass;

   apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
   apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
   apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();

   assign if0.psel = psel_v[0];  assign if1.psel = psel_v[1];  assign if2.psel = psel_v[2];
   assign if0.penable = penable; assign if1.penable = penable; assign if2.penable = penable;
   assign if0.pwrite = pwrite;   assign if1.pwrite = pwrite;   assign if2.pwrite = pwrite;
   assign if0.pprot = pprot;     assign if1.pprot = pprot;     assign if2.pprot = pprot;
   assign if0.paddr = paddr;     assign if1.paddr = paddr;     assign if2.paddr = paddr;
   assign if0.pwdata = pwdata;   assign if1.pwdata = pwdata;   assign if2.pwdata = pwdata;
   assign if0.pstrb = pstrb;     assign if1.pstrb = pstrb;     assign if2.pstrb = pstrb;

   assign rdy = {if2.pready, if1.pready, if0.pready};
   assign err = {if2.pslverr, if1.pslverr, if0.pslverr};
   assign rdat[0] = if0.prdata;
   assign rdat[1] = if1.prdata;
   assign rdat[2] = if2.prdata;

   apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(BASE), .WAIT_STATES(0), .RO_MASK(ROM)) u_ws0 (
      .aclk(aclk), .areset(rst), .s_apb(if0), .reg_q(regq0), .wr_pulse(wrp0), .ro_in(ro_in));
   apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(BASE), .WAIT_STATES(3), .RO_MASK(ROM)) u_ws3 (
      .aclk(aclk), .areset(rst), .s_apb(if1), .reg_q(regq1), .wr_pulse(wrp1), .ro_in(ro_in));
   apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(BASE), .WAIT_STATES(2), .RO_MASK(ROM)) u_ws2 (
      .aclk(aclk), .areset(rst), .s_apb(if2), .reg_q(regq2), .wr_pulse(wrp2), .ro_in(ro_in));

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   function automatic logic [31:0] word(input logic [511:0] q, input int i);
      return q[32*i +: 32];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   // One complete APB transfer on instance d. Entered and left at posedge+1.
   // lat counts access cycles up to and including the one with pready high.
   task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb,
                           input logic scramble, output logic [31:0] rd,
                           output logic er, output int lat, output logic stable);
      logic [31:0] first;
      logic        seen;
      logic        done;
      psel_v[d] = 1'b1; penable = 1'b0; pwrite = wr;
      paddr = addr; pwdata = wd; pstrb = strb;
      @(posedge aclk); #1;
      penable = 1'b1;
      lat = 0; stable = 1'b1; seen = 1'b0; done = 1'b0; rd = '0; er = 1'b0; first = '0;
      while (!done) begin
         @(negedge aclk);
         lat++;
         if (!seen) begin
            first = rdat[d];
            seen  = 1'b1;
         end else if (rdat[d] !== first) begin
            stable = 1'b0;
         end
         if (rdy[d]) begin
            rd = rdat[d];
            er = err[d];
            @(posedge aclk); #1;
            done = 1'b1;
         end else if (lat >= 32) begin
            check("xfer timeout", {63'd0, rdy[d]}, 64'd1);
            done = 1'b1;
         end else begin
            @(posedge aclk); #1;
            if (scramble) begin
               paddr  = paddr ^ 32'h4;
               pwdata = ~pwdata;
            end
         end
      end
      psel_v[d] = 1'b0;
      penable   = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        stb;
      logic [511:0] snap;

      n_chk = 0; n_pass = 0;
      rst = 1'b1; psel_v = '0; penable = 1'b0; pwrite = 1'b0; pprot = 3'b010;
      paddr = '0; pwdata = '0; pstrb = '0;
      for (int i = 0; i < 16; i++) ro_in[32*i +: 32] = 32'hA000_0000 | i;

      // Reset state
      repeat (3) @(posedge aclk);
      #1;
      check("rst pready0", {63'd0, rdy[0]}, 64'd0);
      check("rst pready1", {63'd0, rdy[1]}, 64'd0);
      check("rst pslverr0", {63'd0, err[0]}, 64'd0);
      check("rst prdata0", {32'd0, rdat[0]}, 64'd0);
      check("rst regq0 nonzero", {63'd0, |regq0}, 64'd0);
      check("rst wrpulse0", {48'd0, wrp0}, 64'd0);
      rst = 1'b0;
      idle(1);

      // Basic write / read back, zero wait states
      apb_xfer(0, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, er, lat, stb);
      check("ws0 wr lat", lat, 1);
      check("ws0 wr err", {63'd0, er}, 64'd0);
      check("ws0 reg1", word(regq0, 1), 32'hDEAD_BEEF);
      check("ws0 wrpulse", {48'd0, wrp0}, 64'h0002);
      idle(1);
      check("ws0 wrpulse gone", {48'd0, wrp0}, 64'd0);
      apb_xfer(0, 1'b0, BASE + 32'h4, 32'h0, 4'h0, 1'b0, rd, er, lat, stb);
      check("ws0 rd data", rd, 32'hDEAD_BEEF);
      check("ws0 rd err", {63'd0, er}, 64'd0);
      idle(1);

      // Byte strobes
      apb_xfer(0, 1'b1, BASE + 32'h8, 32'h1122_3344, 4'hF, 1'b0, rd, er, lat, stb);
      apb_xfer(0, 1'b1, BASE + 32'h8, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, er, lat, stb);
      check("strb reg2", word(regq0, 2), 32'h11BB_33DD);
      apb_xfer(0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, 1'b0, rd, er, lat, stb);
      check("strb0 wrpulse", {48'd0, wrp0}, 64'h0010);
      check("strb0 reg4", word(regq0, 4), 32'h0);
      idle(1);

      // Error cases
      apb_xfer(0, 1'b0, BASE + 32'h40, 32'h0, 4'hF, 1'b0, rd, er, lat, stb);
      check("oob rd data", rd, 32'h0);
      check("oob rd err", {63'd0, er}, 64'd1);
      snap = regq0;
      apb_xfer(0, 1'b1, BASE + 32'h2, 32'h1234_5678, 4'hF, 1'b0, rd, er, lat, stb);
      check("misalign wr err", {63'd0, er}, 64'd1);
      check("misalign wrpulse", {48'd0, wrp0}, 64'd0);
      check("misalign no change", {63'd0, (regq0 == snap)}, 64'd1);
      apb_xfer(0, 1'b1, BASE + 32'hC, 32'h5555_5555, 4'hF, 1'b0, rd, er, lat, stb);
      check("ro wr err", {63'd0, er}, 64'd1);
      check("ro wrpulse", {48'd0, wrp0}, 64'd0);
      check("ro slot", word(regq0, 3), 32'h0);
      apb_xfer(0, 1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b0, rd, er, lat, stb);
      check("ro rd data", rd, 32'hA000_0003);
      check("ro rd err", {63'd0, er}, 64'd0);
      apb_xfer(0, 1'b0, BASE - 32'h4, 32'h0, 4'h0, 1'b0, rd, er, lat, stb);
      check("below base err", {63'd0, er}, 64'd1);
      idle(1);

      // Back-to-back write then read, no idle cycle between them
      apb_xfer(0, 1'b1, BASE, 32'hCAFE_F00D, 4'hF, 1'b0, rd, er, lat, stb);
      apb_xfer(0, 1'b0, BASE, 32'h0, 4'h0, 1'b0, rd, er, lat, stb);
      check("b2b rd data", rd, 32'hCAFE_F00D);
      check("b2b rd lat", lat, 1);
      idle(1);

      // Three wait states; bus address scrambled while waiting
      apb_xfer(1, 1'b1, BASE + 32'h1C, 32'h1234_5678, 4'hF, 1'b0, rd, er, lat, stb);
      check("ws3 wr lat", lat, 4);
      check("ws3 reg7", word(regq1, 7), 32'h1234_5678);
      apb_xfer(1, 1'b0, BASE + 32'h1C, 32'h0, 4'h0, 1'b1, rd, er, lat, stb);
      check("ws3 rd lat", lat, 4);
      check("ws3 rd data", rd, 32'h1234_5678);
      check("ws3 prdata stable", {63'd0, stb}, 64'd1);
      @(negedge aclk);
      check("ws3 pready one cycle", {63'd0, rdy[1]}, 64'd0);
      @(posedge aclk); #1;

      // psel dropped mid-access: no commit, FSM back to idle
      psel_v[2] = 1'b1; pwrite = 1'b1; paddr = BASE + 32'h14; pwdata = 32'h55AA_55AA;
      pstrb = 4'hF; penable = 1'b0;
      @(posedge aclk); #1;
      penable = 1'b1;
      @(posedge aclk); #1;
      psel_v[2] = 1'b0; penable = 1'b0;
      idle(2);
      check("abort reg5", word(regq2, 5), 32'h0);
      check("abort wrpulse", {48'd0, wrp2}, 64'd0);
      check("abort pready", {63'd0, rdy[2]}, 64'd0);
      apb_xfer(2, 1'b0, BASE + 32'h14, 32'h0, 4'h0, 1'b0, rd, er, lat, stb);
      check("after abort lat", lat, 3);
      check("after abort data", rd, 32'h0);

      // Reset asserted during ACCESS
      apb_xfer(2, 1'b1, BASE + 32'h18, 32'h0000_0066, 4'hF, 1'b0, rd, er, lat, stb);
      check("ws2 reg6", word(regq2, 6), 32'h66);
      psel_v[2] = 1'b1; pwrite = 1'b1; paddr = BASE + 32'h18; pwdata = 32'h7777_7777;
      pstrb = 4'hF; penable = 1'b0;
      @(posedge aclk); #1;
      penable = 1'b1;
      @(posedge aclk); #1;
      rst = 1'b1;
      @(posedge aclk); #1;
      check("rst mid pready", {63'd0, rdy[2]}, 64'd0);
      check("rst mid regq2 nonzero", {63'd0, |regq2}, 64'd0);
      check("rst mid regq0 nonzero", {63'd0, |regq0}, 64'd0);
      psel_v[2] = 1'b0; penable = 1'b0; rst = 1'b0;
      idle(3);
      check("post rst regq2 nonzero", {63'd0, |regq2}, 64'd0);
      check("post rst wrpulse", {48'd0, wrp2}, 64'd0);
      check("post rst pready", {63'd0, rdy[2]}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
